ext_memory_controller: RTL and testbench
========================================

Name: ext_memory_controller

Overview:
Parametrised successor to the single-field PDP-8 memory controller.
- Backs 2^FIELD_BITS fields of 2^ADDR_WIDTH words each (default 8 x 4096 = 32K words of 12 bits).
- Adds a configurable access latency, busy/error status and a PDP-8 auto-index read-modify-write cycle.
- Sits between the CPU datapath/sequencer and the word-addressed core array; exactly one request is in flight at a time.

Parameters:
WORD_WIDTH, 12, data word width in bits
ADDR_WIDTH, 12, address bits within a field
FIELD_BITS, 3, field-select bits; total depth = 2^(FIELD_BITS+ADDR_WIDTH)
LATENCY, 2, ACCESS-state cycles per access (legal range 1..15)
AUTOINC_LO, 12'o0010, first auto-index address (within any field)
AUTOINC_HI, 12'o0017, last auto-index address

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
field  input  FIELD_BITS  field select, sampled at accept
address  input  ADDR_WIDTH  word address within the field, sampled at accept
write_data  input  WORD_WIDTH  write data, sampled at accept
read_enable  input  1  read request
read_type  input  2  0 = INSTR_FETCH, 1 = DATA_READ, 2 = INDIRECT_READ, 3 = reserved (treated as DATA_READ)
write_enable  input  1  write request
read_data  output  WORD_WIDTH  read result, held until the next read completes
operation_done  output  1  one-cycle completion pulse
busy  output  1  request in flight
error  output  1  one-cycle pulse coincident with operation_done on an illegal request

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: read_data = 0, operation_done = 0, busy = 0, error = 0, state = IDLE. The memory array is NOT cleared by reset.
- States: IDLE, ACCESS, WRITEBACK, DONE.
- IDLE accepts a request on a rising edge where read_enable or write_enable is high.
  - On accept, latch field, address, write_data and read_type, load the latency counter with LATENCY, and go to ACCESS.
  - Enables may be one-cycle pulses or levels. A level still high in DONE/IDLE is a new request.
- ACCESS: decrement the counter each cycle; busy = 1. On the edge where the counter reaches 0:
  - Write: commit write_data to mem[{field,address}] and go to DONE.
  - Read: capture mem[{field,address}] into an internal register. Go to WRITEBACK if auto-index applies; otherwise load read_data and go to DONE.
- WRITEBACK (one cycle, busy = 1): word = (captured + 1) mod 2^WORD_WIDTH. Write the word back to the same location, load it into read_data, go to DONE.
- DONE (one cycle): operation_done = 1, busy = 1, then return to IDLE. The next request can be accepted on the edge leaving DONE.
- Latency:
  - Accepting edge = edge 0.
  - Plain op: operation_done high in cycle LATENCY+1 after edge 0.
  - Auto-index op: operation_done high in cycle LATENCY+2.
- Auto-index applies only when all of the following hold:
  - INDIRECT_READ;
  - AUTOINC_LO <= address <= AUTOINC_HI;
  - AUTOINDEX_EN is defined.
  It applies in every field, and 12'o7777 wraps to 12'o0000.
- read_enable and write_enable both high at accept:
  - Go to ACCESS as normal.
  - No memory write is performed and read_data is unchanged.
  - error pulses with operation_done.
- Enables while busy are ignored; no queuing.
- Reset mid-operation: return to IDLE on that edge and clear the outputs.
  - A write is performed only if the reset edge is later than the commit edge.
  - For auto-index, the captured-read/writeback pair is not atomic against reset. A reset during WRITEBACK suppresses the writeback.
- INSTR_FETCH and DATA_READ are functionally identical. read_type is kept for trace and future cache use.

Optional Feature:
AUTOINDEX_EN
- Defined: INDIRECT_READ to AUTOINC_LO..AUTOINC_HI performs the WRITEBACK increment described above, and read_data returns the incremented value.
- Undefined: the WRITEBACK state is unreachable and INDIRECT_READ behaves exactly as DATA_READ, with no memory modification.

Test Plan:
- Write field 0, address 12'o0200, data 12'o0333, then DATA_READ of the same location. Required: read_data = 12'o0333; operation_done 3 cycles after each accept (LATENCY = 2); busy high for 3 cycles.
- Write field 5, address 12'o0200, data 12'o1234. Required: field 0 address 12'o0200 still reads 12'o0333 and field 5 reads 12'o1234 (no field aliasing).
- With AUTOINDEX_EN: mem[f0:12'o0010] = 12'o7777, then INDIRECT_READ. Required: read_data = 12'o0000, operation_done 4 cycles after accept, and a DATA_READ then returns 12'o0000. Without AUTOINDEX_EN, the same sequence returns 12'o7777 twice.
- INDIRECT_READ of 12'o0020 holding 12'o0055. Required: read_data = 12'o0055 and memory unchanged (outside the auto-index window).
- read_enable and write_enable both high, address 12'o0200, data 12'o7070. Required: error = 1 with operation_done, mem[12'o0200] still 12'o0333, read_data unchanged.
- Write 12'o4444 to 12'o0300 with reset asserted the cycle after accept (before the commit edge). Required: all outputs 0 next cycle, mem[12'o0300] retains its prior value, and a new request accepted after reset completes normally.

Source files
------------

// File: rtl/ext_memory_controller.sv
// Multi-field PDP-8 style memory controller with programmable access latency,
// conflict error reporting and optional auto-index writeback (macro AUTOINDEX_EN).
module ext_memory_controller #(
  parameter int WORD_WIDTH = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int FIELD_BITS = 3,
  parameter int LATENCY    = 2,
  parameter logic [ADDR_WIDTH-1:0] AUTOINC_LO = 12'o0010,
  parameter logic [ADDR_WIDTH-1:0] AUTOINC_HI = 12'o0017
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FIELD_BITS-1:0] field,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [WORD_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  input  logic [1:0]            read_type,
  input  logic                  write_enable,
  output logic [WORD_WIDTH-1:0] read_data,
  output logic                  operation_done,
  output logic                  busy,
  output logic                  error
);

  localparam int DEPTH = 1 << (FIELD_BITS + ADDR_WIDTH);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ACCESS    = 2'd1;
  localparam logic [1:0] WRITEBACK = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  localparam logic [1:0] RT_INDIRECT = 2'd2;

`ifdef AUTOINDEX_EN
  localparam logic AUTOINDEX_ON = 1'b1;
`else
  localparam logic AUTOINDEX_ON = 1'b0;
`endif

  logic [1:0]                         state;
  logic [3:0]                         lat_cnt;
  logic [FIELD_BITS-1:0]              req_field;
  logic [ADDR_WIDTH-1:0]              req_addr;
  logic [WORD_WIDTH-1:0]              req_wdata;
  logic [1:0]                         req_type;
  logic                               req_write;
  logic                               req_conflict;
  logic [WORD_WIDTH-1:0]              captured;
  logic [WORD_WIDTH-1:0]              incremented;
  logic [FIELD_BITS+ADDR_WIDTH-1:0]   mem_addr;
  logic                               accept;
  logic                               commit;
  logic                               use_autoindex;

  logic [WORD_WIDTH-1:0] mem [0:DEPTH-1];

  // A new request may be taken in IDLE or on the edge leaving DONE.
  assign accept        = ((state == IDLE) || (state == DONE)) && (read_enable || write_enable);
  assign commit        = (state == ACCESS) && (lat_cnt == 4'd1);
  assign mem_addr      = {req_field, req_addr};
  assign incremented   = captured + 1'b1;
  assign use_autoindex = AUTOINDEX_ON && (req_type == RT_INDIRECT) && !req_write && !req_conflict &&
                         (req_addr >= AUTOINC_LO) && (req_addr <= AUTOINC_HI);

  assign operation_done = (state == DONE);
  assign busy           = (state != IDLE);
  assign error          = (state == DONE) && req_conflict;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lat_cnt      <= 4'd0;
      read_data    <= '0;
      req_conflict <= 1'b0;
      req_write    <= 1'b0;
      req_field    <= '0;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_type     <= 2'd0;
      captured     <= '0;
    end else if (accept) begin
      req_field    <= field;
      req_addr     <= address;
      req_wdata    <= write_data;
      req_type     <= read_type;
      req_write    <= write_enable && !read_enable;
      req_conflict <= write_enable && read_enable;
      lat_cnt      <= 4'(LATENCY);
      state        <= ACCESS;
    end else begin
      case (state)
        ACCESS: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (commit) begin
            captured <= mem[mem_addr];
            if (req_conflict || req_write) begin
              state <= DONE;
            end else if (use_autoindex) begin
              state <= WRITEBACK;
            end else begin
              read_data <= mem[mem_addr];
              state     <= DONE;
            end
          end
        end
        WRITEBACK: begin
          read_data <= incremented;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array writes are gated by reset so an aborted op never touches memory.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (commit && req_write) begin
        mem[mem_addr] <= req_wdata;
      end else if (state == WRITEBACK) begin
        mem[mem_addr] <= incremented;
      end
    end
  end

endmodule

// File: tb/tb_ext_memory_controller.sv
// Directed self-checking bench for ext_memory_controller (LATENCY = 2).
module tb_ext_memory_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  field;
  logic [11:0] address;
  logic [11:0] write_data;
  logic        read_enable;
  logic [1:0]  read_type;
  logic        write_enable;
  logic [11:0] read_data;
  logic        operation_done;
  logic        busy;
  logic        error;

  int n_checks = 0;
  int n_fails  = 0;

  localparam logic [1:0] RT_FETCH = 2'd0;
  localparam logic [1:0] RT_DATA  = 2'd1;
  localparam logic [1:0] RT_IND   = 2'd2;

`ifdef AUTOINDEX_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  ext_memory_controller dut (
    .clk(clk), .reset(reset), .field(field), .address(address),
    .write_data(write_data), .read_enable(read_enable), .read_type(read_type),
    .write_enable(write_enable), .read_data(read_data),
    .operation_done(operation_done), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Issues one pulsed request and measures cycles from the accepting edge to operation_done.
  task automatic run_op(input logic re, input logic we, input logic [2:0] f, input logic [11:0] a,
                        input logic [11:0] wd, input logic [1:0] rt,
                        output int lat, output int busy_cycles, output logic err);
    @(negedge clk);
    read_enable = re; write_enable = we; field = f; address = a; write_data = wd; read_type = rt;
    @(posedge clk); #1;
    read_enable = 1'b0; write_enable = 1'b0;
    lat = -1; busy_cycles = 0; err = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (operation_done) begin
        lat = c; err = error;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; read_enable = 1'b0; write_enable = 1'b0;
    field = '0; address = '0; write_data = '0; read_type = RT_FETCH;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (read_data !== 12'o0000) begin n_fails++; $display("[TB] FAIL rst_read_data: got %0o expected 0", read_data); end
    n_checks++; if (operation_done !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_done: got %0b expected 0", operation_done); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_busy: got %0b expected 0", busy); end
    n_checks++; if (error !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_error: got %0b expected 0", error); end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    int lat, bc; logic err;
    run_op(1'b0, 1'b1, 3'd0, 12'o0200, 12'o0333, RT_FETCH, lat, bc, err);
    n_checks++; if (lat !== 3) begin n_fails++; $display("[TB] FAIL wr_latency: got %0d expected 3", lat); end
    n_checks++; if (bc !== 3) begin n_fails++; $display("[TB] FAIL wr_busy_cycles: got %0d expected 3", bc); end
    n_checks++; if (err !== 1'b0) begin n_fails++; $display("[TB] FAIL wr_error: got %0b expected 0", err); end
    run_op(1'b1, 1'b0, 3'd0, 12'o0200, 12'o0000, RT_DATA, lat, bc, err);
    n_checks++; if (read_data !== 12'o0333) begin n_fails++; $display("[TB] FAIL rd_data: got %0o expected 333", read_data); end
    n_checks++; if (lat !== 3) begin n_fails++; $display("[TB] FAIL rd_latency: got %0d expected 3", lat); end
    n_checks++; if (bc !== 3) begin n_fails++; $display("[TB] FAIL rd_busy_cycles: got %0d expected 3", bc); end
  endtask

  task automatic test_fields();
    int lat, bc; logic err;
    run_op(1'b0, 1'b1, 3'd5, 12'o0200, 12'o1234, RT_FETCH, lat, bc, err);
    run_op(1'b1, 1'b0, 3'd0, 12'o0200, 12'o0000, RT_FETCH, lat, bc, err);
    n_checks++; if (read_data !== 12'o0333) begin n_fails++; $display("[TB] FAIL field0_alias: got %0o expected 333", read_data); end
    run_op(1'b1, 1'b0, 3'd5, 12'o0200, 12'o0000, RT_DATA, lat, bc, err);
    n_checks++; if (read_data !== 12'o1234) begin n_fails++; $display("[TB] FAIL field5_data: got %0o expected 1234", read_data); end
  endtask

  task automatic test_autoindex();
    int lat, bc; logic err;
    logic [11:0] exp1, exp2;
    run_op(1'b0, 1'b1, 3'd0, 12'o0010, 12'o7777, RT_FETCH, lat, bc, err);
    run_op(1'b1, 1'b0, 3'd0, 12'o0010, 12'o0000, RT_IND, lat, bc, err);
    exp1 = AI ? 12'o0000 : 12'o7777;
    n_checks++; if (read_data !== exp1) begin n_fails++; $display("[TB] FAIL ai_wrap_data: got %0o expected %0o", read_data, exp1); end
    n_checks++; if (lat !== (AI ? 4 : 3)) begin n_fails++; $display("[TB] FAIL ai_latency: got %0d expected %0d", lat, AI ? 4 : 3); end
    n_checks++; if (bc !== (AI ? 4 : 3)) begin n_fails++; $display("[TB] FAIL ai_busy_cycles: got %0d expected %0d", bc, AI ? 4 : 3); end
    run_op(1'b1, 1'b0, 3'd0, 12'o0010, 12'o0000, RT_DATA, lat, bc, err);
    n_checks++; if (read_data !== exp1) begin n_fails++; $display("[TB] FAIL ai_mem_after: got %0o expected %0o", read_data, exp1); end
    // Top of window in another field.
    run_op(1'b0, 1'b1, 3'd3, 12'o0017, 12'o0100, RT_FETCH, lat, bc, err);
    run_op(1'b1, 1'b0, 3'd3, 12'o0017, 12'o0000, RT_IND, lat, bc, err);
    exp2 = AI ? 12'o0101 : 12'o0100;
    n_checks++; if (read_data !== exp2) begin n_fails++; $display("[TB] FAIL ai_field3_hi: got %0o expected %0o", read_data, exp2); end
  endtask

  task automatic test_window();
    int lat, bc; logic err;
    run_op(1'b0, 1'b1, 3'd0, 12'o0020, 12'o0055, RT_FETCH, lat, bc, err);
    run_op(1'b1, 1'b0, 3'd0, 12'o0020, 12'o0000, RT_IND, lat, bc, err);
    n_checks++; if (read_data !== 12'o0055) begin n_fails++; $display("[TB] FAIL win_above_data: got %0o expected 55", read_data); end
    n_checks++; if (lat !== 3) begin n_fails++; $display("[TB] FAIL win_above_latency: got %0d expected 3", lat); end
    run_op(1'b1, 1'b0, 3'd0, 12'o0020, 12'o0000, RT_DATA, lat, bc, err);
    n_checks++; if (read_data !== 12'o0055) begin n_fails++; $display("[TB] FAIL win_above_mem: got %0o expected 55", read_data); end
    run_op(1'b0, 1'b1, 3'd0, 12'o0007, 12'o0042, RT_FETCH, lat, bc, err);
    run_op(1'b1, 1'b0, 3'd0, 12'o0007, 12'o0000, RT_IND, lat, bc, err);
    n_checks++; if (read_data !== 12'o0042) begin n_fails++; $display("[TB] FAIL win_below_data: got %0o expected 42", read_data); end
  endtask

  task automatic test_conflict();
    int lat, bc; logic err;
    run_op(1'b1, 1'b1, 3'd0, 12'o0200, 12'o7070, RT_DATA, lat, bc, err);
    n_checks++; if (err !== 1'b1) begin n_fails++; $display("[TB] FAIL conf_error: got %0b expected 1", err); end
    n_checks++; if (lat !== 3) begin n_fails++; $display("[TB] FAIL conf_latency: got %0d expected 3", lat); end
    n_checks++; if (read_data !== 12'o0042) begin n_fails++; $display("[TB] FAIL conf_read_data: got %0o expected 42", read_data); end
    run_op(1'b1, 1'b0, 3'd0, 12'o0200, 12'o0000, RT_DATA, lat, bc, err);
    n_checks++; if (read_data !== 12'o0333) begin n_fails++; $display("[TB] FAIL conf_mem: got %0o expected 333", read_data); end
    n_checks++; if (err !== 1'b0) begin n_fails++; $display("[TB] FAIL conf_error_clear: got %0b expected 0", err); end
  endtask

  task automatic test_reset_mid();
    int lat, bc; logic err;
    run_op(1'b0, 1'b1, 3'd0, 12'o0300, 12'o0111, RT_FETCH, lat, bc, err);
    @(negedge clk);
    write_enable = 1'b1; field = 3'd0; address = 12'o0300; write_data = 12'o4444;
    @(posedge clk); #1;
    write_enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_busy: got %0b expected 0", busy); end
    n_checks++; if (operation_done !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_done: got %0b expected 0", operation_done); end
    n_checks++; if (read_data !== 12'o0000) begin n_fails++; $display("[TB] FAIL mid_read_data: got %0o expected 0", read_data); end
    n_checks++; if (error !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_error: got %0b expected 0", error); end
    run_op(1'b1, 1'b0, 3'd0, 12'o0300, 12'o0000, RT_DATA, lat, bc, err);
    n_checks++; if (read_data !== 12'o0111) begin n_fails++; $display("[TB] FAIL mid_mem_kept: got %0o expected 111", read_data); end
    n_checks++; if (lat !== 3) begin n_fails++; $display("[TB] FAIL mid_recover_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_back_to_back();
    int first, second;
    first = -1; second = -1;
    @(negedge clk);
    read_enable = 1'b1; field = 3'd5; address = 12'o0200; read_type = RT_DATA;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (operation_done) begin
        if (first < 0) first = c;
        else begin
          second = c;
          read_enable = 1'b0;
          break;
        end
      end
    end
    read_enable = 1'b0;
    n_checks++; if (first !== 3) begin n_fails++; $display("[TB] FAIL b2b_first: got %0d expected 3", first); end
    n_checks++; if (second !== 6) begin n_fails++; $display("[TB] FAIL b2b_second: got %0d expected 6", second); end
    n_checks++; if (read_data !== 12'o1234) begin n_fails++; $display("[TB] FAIL b2b_data: got %0o expected 1234", read_data); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL b2b_idle: got %0b expected 0", busy); end
  endtask

  initial begin
    $display("[TB] starting, auto-index %0s", AI ? "enabled" : "disabled");
    test_reset();
    test_write_read();
    test_fields();
    test_autoindex();
    test_window();
    test_conflict();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
